rom_note_sequencer: RTL

Sequences an 8-bit synchronous block ROM holding a music score and plays it note by note. Each score entry is two bytes at consecutive addresses: a note code, then a duration in beats. The block drives the ROM address, handles the ROM's 1-cycle read latency, times each note with an internal beat prescaler, and presents the current note to the tone generator. It sits between the score ROM and the tone divider, under control of a CPU-written control register.

---
 rtl/rom_note_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/rom_note_sequencer.sv
// Walks a two-byte-per-entry score (note, beats) in a 1-cycle-latency ROM and presents the playing note.
// 4-cycle fetch gap between notes; no backpressure, pause_i freezes beat timing and stop_i aborts at once.
module rom_note_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int BEAT_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  pause_i,
    input  logic                  loop_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] note_o,
    output logic                  note_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int PW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(BEAT_DIV - 1);
    localparam logic [DATA_WIDTH-1:0] END_MARK = '1;

    typedef enum logic [2:0] {
        IDLE,
        FN,
        LN,
        FD,
        LD,
        PLAY
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] dur;
    logic [PW-1:0]         presc;

    assign rom_addr_o = ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            base         <= '0;
            dur          <= '0;
            presc        <= '0;
            note_o       <= '0;
            note_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (stop_i) begin
                // pointer is left where it was so a debugger can see where playback stopped
                state        <= IDLE;
                note_valid_o <= 1'b0;
                busy_o       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            ptr    <= start_addr_i;
                            base   <= start_addr_i;
                            busy_o <= 1'b1;
                            state  <= FN;
                        end
                    end
                    FN: state <= LN;
                    LN: begin
                        if (rom_data_i == END_MARK) begin
                            if (loop_i) begin
                                ptr   <= base;
                                state <= FN;
                            end else begin
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                                state  <= IDLE;
                            end
                        end else begin
                            note_o <= rom_data_i;
                            ptr    <= ptr + ADDR_WIDTH'(1);
                            state  <= FD;
                        end
                    end
                    FD: state <= LD;
                    LD: begin
                        dur          <= (rom_data_i == '0) ? DATA_WIDTH'(1) : rom_data_i;
                        ptr          <= ptr + ADDR_WIDTH'(1);
                        presc        <= '0;
                        note_valid_o <= 1'b1;
                        state        <= PLAY;
                    end
                    PLAY: begin
                        if (!pause_i) begin
                            if (presc == PRESC_MAX) begin
                                presc <= '0;
                                dur   <= dur - DATA_WIDTH'(1);
                                if (dur == DATA_WIDTH'(1)) begin
                                    note_valid_o <= 1'b0;
                                    state        <= FN;
                                end
                            end else begin
                                presc <= presc + PW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
